// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank: error-flag bit positions
// and the byte-strobe merge used by every entry.
package reg_bank_pkg;

    localparam int unsigned ERR_COLLISION = 0;
    localparam int unsigned ERR_RANGE     = 1;
    localparam int unsigned ERR_UNINIT    = 2;
    localparam int unsigned ERR_W         = 3;

    // Returns the new byte when its strobe is set, otherwise keeps the old byte.
    function automatic logic [7:0] strb_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/reg_bank_entry.sv
// One register-bank word with a valid bit; byte-strobed write and a valid-clear
// that a same-cycle write overrides.
module reg_bank_entry
    import reg_bank_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             clr,
    input  logic [NB-1:0]    strb,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] merged;

    always_comb begin
        merged = data;
        for (int b = 0; b < NB; b++) begin
            merged[8*b +: 8] = strb_merge(data[8*b +: 8], wdata[8*b +: 8], strb[b]);
        end
    end

    // Clear first, so a write in the same cycle leaves this entry valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end
            if (we) begin
                data  <= merged;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank: strobed write port, registered read port with
// valid flag, per-entry valid tracking and pulse/sticky access-error reporting.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned NB    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [NB-1:0]    wr_strb,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clear_en,
    output logic [ERR_W-1:0] err_pulse,
    output logic [ERR_W-1:0] err_status,
    input  logic             err_clr
);

    logic [DEPTH-1:0] ent_we;
    logic [DEPTH-1:0] ent_valid;
    logic [WIDTH-1:0] ent_data [DEPTH];

    logic             rd_hit;
    logic             wr_hit;
    logic             rd_sel_valid;
    logic [WIDTH-1:0] rd_sel_data;
    logic [ERR_W-1:0] err_next;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign ent_we[i] = wr_en && (wr_addr == AW'(i));

        reg_bank_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .reset (reset),
            .we    (ent_we[i]),
            .clr   (clear_en),
            .strb  (wr_strb),
            .wdata (wr_data),
            .data  (ent_data[i]),
            .valid (ent_valid[i])
        );
    end

    // Read mux over pre-write contents; an address matching no entry is out of range.
    always_comb begin
        rd_hit       = 1'b0;
        wr_hit       = 1'b0;
        rd_sel_valid = 1'b0;
        rd_sel_data  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_hit       = 1'b1;
                rd_sel_valid = ent_valid[i];
                rd_sel_data  = ent_data[i];
            end
            if (wr_addr == AW'(i)) begin
                wr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        err_next                = '0;
        err_next[ERR_COLLISION] = rd_en && wr_en && rd_hit && (rd_addr == wr_addr);
        err_next[ERR_RANGE]     = (rd_en && !rd_hit) || (wr_en && !wr_hit);
        err_next[ERR_UNINIT]    = rd_en && rd_hit && !rd_sel_valid;
    end

    // A new error beats err_clr in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err_pulse  <= '0;
            err_status <= '0;
        end else begin
            rd_valid  <= rd_en;
            err_pulse <= err_next;
            if (rd_en) begin
                rd_data <= rd_sel_data;
            end
            err_status <= (err_clr ? '0 : err_status) | err_next;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=32, DEPTH=6): directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_reg_bank;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       wr_strb;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             clear_en;
    logic [2:0]       err_pulse;
    logic [2:0]       err_status;
    logic             err_clr;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] mem [DEPTH];
    bit          vld [DEPTH];
    logic [31:0] m_rd_data;
    bit          m_rd_valid;
    logic [2:0]  m_pulse;
    logic [2:0]  m_status;

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .clear_en   (clear_en),
        .err_pulse  (err_pulse),
        .err_status (err_status),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            vld[i] = 1'b0;
        end
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_pulse    = '0;
        m_status   = '0;
    endfunction

    // Applies one clock edge worth of the bank's rules to the model.
    function automatic void model_update();
        bit         rin;
        bit         win;
        logic [2:0] e;
        int         ra;
        int         wa;
        ra  = int'(rd_addr);
        wa  = int'(wr_addr);
        rin = ra < DEPTH;
        win = wa < DEPTH;
        e   = '0;
        m_rd_valid = rd_en;
        if (rd_en) begin
            if (rin) begin
                m_rd_data = mem[ra];
                if (!vld[ra]) e[2] = 1'b1;
            end else begin
                m_rd_data = '0;
                e[1] = 1'b1;
            end
        end
        if (wr_en && !win) e[1] = 1'b1;
        if (rd_en && wr_en && rin && ra == wa) e[0] = 1'b1;
        if (clear_en) begin
            for (int i = 0; i < DEPTH; i++) vld[i] = 1'b0;
        end
        if (wr_en && win) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wa][8*b +: 8] = wr_data[8*b +: 8];
            end
            vld[wa] = 1'b1;
        end
        m_status = (err_clr ? 3'b000 : m_status) | e;
        m_pulse  = e;
    endfunction

    task automatic step(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] ws,
                        input bit re, input int ra, input bit clr, input bit eclr);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        wr_strb  = ws;
        rd_en    = re;
        rd_addr  = AW'(ra);
        clear_en = clr;
        err_clr  = eclr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 4'h0, 0, 0, 0, 0);
    endtask

    // Every-cycle comparison against the model (zeros while reset is high).
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_rd_data", rd_data, 32'h0);
            chk("rst_rd_valid", 32'(rd_valid), 32'h0);
            chk("rst_err_pulse", 32'(err_pulse), 32'h0);
            chk("rst_err_status", 32'(err_status), 32'h0);
        end else begin
            chk("rd_data", rd_data, m_rd_data);
            chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
            chk("err_status", 32'(err_status), 32'(m_status));
        end
    end

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_strb  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        clear_en = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_status", 32'(err_status), 32'h0);
        reset = 1'b0;
        model_reset();

        // Full write then read
        step(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        step(0, 0, 32'h0, 4'h0, 1, 3, 0, 0);
        chk("full_wr_data", rd_data, 32'hDEADBEEF);
        chk("full_wr_valid", 32'(rd_valid), 32'h1);
        chk("full_wr_err", 32'(err_pulse), 32'h0);

        // Partial strobed write
        step(1, 3, 32'h11223344, 4'b0101, 0, 0, 0, 0);
        step(0, 0, 32'h0, 4'h0, 1, 3, 0, 0);
        chk("partial_wr", rd_data, 32'hDE22BE44);

        // Collision: read-before-write, write still commits
        step(1, 2, 32'h9, 4'hF, 0, 0, 0, 0);
        step(1, 2, 32'h5, 4'hF, 1, 2, 0, 0);
        chk("coll_data", rd_data, 32'h9);
        chk("coll_err", 32'(err_pulse), 32'h1);
        step(0, 0, 32'h0, 4'h0, 1, 2, 0, 0);
        chk("coll_after", rd_data, 32'h5);
        chk("coll_after_err", 32'(err_pulse), 32'h0);

        // Out-of-range read and sticky status
        step(0, 0, 32'h0, 4'h0, 0, 0, 0, 1);
        step(0, 0, 32'h0, 4'h0, 1, 7, 0, 0);
        chk("range_data", rd_data, 32'h0);
        chk("range_valid", 32'(rd_valid), 32'h1);
        chk("range_pulse", 32'(err_pulse), 32'h2);
        chk("range_status", 32'(err_status), 32'h2);
        idle();
        chk("range_hold_pulse", 32'(err_pulse), 32'h0);
        chk("range_hold_status", 32'(err_status), 32'h2);
        chk("idle_valid", 32'(rd_valid), 32'h0);
        step(0, 0, 32'h0, 4'h0, 1, 7, 0, 1);
        chk("range_set_wins", 32'(err_status), 32'h2);
        step(0, 0, 32'h0, 4'h0, 0, 0, 0, 1);
        chk("status_cleared", 32'(err_status), 32'h0);
        step(1, 6, 32'h1, 4'hF, 0, 0, 0, 0);
        chk("wr_range_pulse", 32'(err_pulse), 32'h2);

        // Uninitialised reads and clear combined with a write
        step(0, 0, 32'h0, 4'h0, 1, 5, 0, 1);
        chk("uninit_data", rd_data, 32'h0);
        chk("uninit_pulse", 32'(err_pulse), 32'h4);
        step(1, 1, 32'hCAFE0001, 4'hF, 0, 0, 1, 0);
        step(0, 0, 32'h0, 4'h0, 1, 1, 0, 0);
        chk("clr_wr_data", rd_data, 32'hCAFE0001);
        chk("clr_wr_err", 32'(err_pulse), 32'h0);
        step(0, 0, 32'h0, 4'h0, 1, 3, 0, 0);
        chk("clr_old_data", rd_data, 32'hDE22BE44);
        chk("clr_old_err", 32'(err_pulse), 32'h4);

        // Back-to-back reads keep rd_valid high
        step(0, 0, 32'h0, 4'h0, 1, 1, 0, 0);
        chk("b2b_valid1", 32'(rd_valid), 32'h1);
        step(0, 0, 32'h0, 4'h0, 1, 2, 0, 0);
        chk("b2b_valid2", 32'(rd_valid), 32'h1);
        chk("b2b_data2", rd_data, 32'h5);

        // Reset during a pending read
        rd_en   = 1'b1;
        rd_addr = AW'(3);
        wr_en   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(rd_valid), 32'h0);
        chk("midrst_data", rd_data, 32'h0);
        chk("midrst_status", 32'(err_status), 32'h0);
        @(posedge clk);
        #1;
        chk("midrst_valid_edge", 32'(rd_valid), 32'h0);
        rd_en = 1'b0;
        reset = 1'b0;
        model_reset();
        idle();
        chk("post_rst_valid", 32'(rd_valid), 32'h0);
        step(0, 0, 32'h0, 4'h0, 1, 3, 0, 0);
        chk("post_rst_data", rd_data, 32'h0);
        chk("post_rst_uninit", 32'(err_pulse), 32'h4);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int wa;
            int ra;
            wa = int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 9) < 3) ? wa : int'($urandom_range(0, 7));
            step($urandom_range(0, 1) == 1, wa, $urandom, 4'($urandom),
                 $urandom_range(0, 2) != 0, ra,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
        end
        idle();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised bank of DEPTH registers, each WIDTH bits, that replaces single-word operand registers in the multiplier datapath. It has one write port with byte strobes and one registered read port with a valid flag. It also tracks which entries have been written and detects access errors: same-address read/write collision, out-of-range address, and reading an unwritten entry. Each error is reported as a one-cycle pulse and as a sticky status bit.

## Interface
Parameters:
- WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH, 8, number of entries, ≥2, need not be a power of two
- AW, $clog2(DEPTH), address width (localparam, derived)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- wr_en  input  1  write request
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- wr_strb  input  WIDTH/8  byte enables; bit i selects wr_data[8i+7:8i]
- rd_en  input  1  read request
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  read data, registered
- rd_valid  output  1  one-cycle pulse, rd_data updated this cycle
- clear_en  input  1  invalidate all entries (data retained, valid bits cleared)
- err_pulse  output  3  per-cycle error flags {uninit, range, collision}
- err_status  output  3  sticky copy of err_pulse
- err_clr  input  1  clear err_status

## Operation
- Write: when wr_en=1 and wr_addr<DEPTH, bytes with wr_strb=1 update at the clock edge and the entry's valid bit is set. A write with wr_strb=0 still sets the valid bit.
- Out-of-range write (wr_addr≥DEPTH): no state change; err_pulse[1] is set.
- Read: when rd_en=1, rd_data is loaded with entry[rd_addr] and rd_valid is asserted on the next cycle.
- Out-of-range read: rd_data=0, rd_valid=1, err_pulse[1] is set.
- Read of an invalid entry: rd_data returns stored contents (0 after reset), rd_valid=1, err_pulse[2] is set.
- Collision: rd_en and wr_en in the same cycle with equal in-range addresses.
  - The read returns the pre-write value (read-before-write).
  - The write still commits.
  - err_pulse[0] is set.
  - Different addresses are legal and raise no error.
- clear_en together with wr_en: the clear applies first, so only the written entry ends valid. A read in the same cycle sees the pre-clear valid bits.
- err_status[i] is set whenever err_pulse[i]=1. err_clr clears it, but a set wins over err_clr in the same cycle.
- When rd_en=0, rd_data holds its last value and rd_valid=0.

## Timing
- Reset (async assert, sync deassert by upstream): all entries=0, all valid bits=0, rd_data=0, rd_valid=0, err_pulse=0, err_status=0.
- Write latency: 1 edge; data is readable by a rd_en issued the following cycle.
- Read latency: 1 cycle, rd_en at edge N gives rd_data/rd_valid after edge N+1.
- err_pulse is registered and aligned with rd_valid. It pulses for one cycle, including for write-only errors.
- Back-to-back reads every cycle are supported; rd_valid stays high continuously.
- Reset asserted mid-read: the pending rd_valid is dropped.

## Structure
- Package reg_bank_pkg holds:
  - ERR_COLLISION=0, ERR_RANGE=1, ERR_UNINIT=2, ERR_W=3
  - a function applying a byte-strobe merge (old, new, strb)
- Sub-module reg_bank_entry: one WIDTH-bit word plus valid bit, with strobed write and clear. It is instantiated DEPTH times in a generate loop.
- The top level holds address decode, the read mux/register and the error logic.

## Test plan
- Reset, then write 0xDEADBEEF to addr 3 with strb=4'hF; read addr 3 next cycle -> rd_data=0xDEADBEEF, rd_valid=1 one cycle later, err_pulse=0.
- Partial write: write 0x11223344 to addr 3 with strb=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44.
- Same-cycle write 0x5 and read at addr 2, which holds 0x9 -> rd_data=0x9, err_pulse=3'b001; next read returns 0x5.
- DEPTH=6: read addr 7 -> rd_data=0, rd_valid=1, err_pulse=3'b010, err_status=3'b010 held until err_clr; err_clr in the same cycle as a new range error -> status stays 3'b010.
- Read unwritten addr 5 after reset -> rd_data=0, err_pulse=3'b100. Then clear_en with a write to addr 1 -> addr 1 reads with no error, addr 3 (written earlier) reads with err_pulse=3'b100.
- Assert reset during a pending read -> rd_valid never pulses, and all outputs are 0 while reset is high.
